// File: rtl/generic_spi_responder.sv
`timescale 1ns / 1ps
// generic_spi_responder
//   SPI responder behind a single chip select. The SPI pins are oversampled on
//   clk and 16- or 24-bit frames are decoded into register write strobes.
//   Read data is pipelined: the word shifted out during a frame is the
//   register addressed by the previous completed frame.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cpol, cpha        SPI mode (latched at frame start)
//   lsbFirst          1: word bit 0 goes on the wire first (latched)
//   largeTransfer     1: 24-bit frame, 0: 16-bit frame (latched)
//   SPI_CLK/CSB/SDI   asynchronous SPI inputs
//   SPI_SDO           responder data out, 0 when idle
//   sdoEnable         pad output enable, high while a frame is active
//   regAddr           address of the last completed frame (also read address)
//   regWrData         write data of the last completed write frame
//   regWrStrobe       one-cycle write pulse
//   regRdData         register contents at regAddr, sampled at frame start
//   frameError        one-cycle pulse when a frame ends with the wrong bit count
//   busy              high while a frame is in progress
module generic_spi_responder #(
    parameter int unsigned CLK_RATE   = 100000000,
    parameter int unsigned BIT_RATE   = 12500000,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbFirst,
    input  logic                  largeTransfer,
    input  logic                  SPI_CLK,
    input  logic                  SPI_CSB,
    input  logic                  SPI_SDI,
    output logic                  SPI_SDO,
    output logic                  sdoEnable,
    output logic [ADDR_WIDTH-1:0] regAddr,
    output logic [15:0]           regWrData,
    output logic                  regWrStrobe,
    input  logic [15:0]           regRdData,
    output logic                  frameError,
    output logic                  busy
);

    // Oversampling needs at least 8 system clocks per SPI bit.
    if (64'(CLK_RATE) < 64'(BIT_RATE) * 64'd8) begin : g_rate_check
        $error("generic_spi_responder: CLK_RATE must be >= 8*BIT_RATE");
    end
    // The frame layout hard-codes a 7-bit address field.
    if (ADDR_WIDTH != 7) begin : g_addr_check
        $error("generic_spi_responder: ADDR_WIDTH must be 7");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_t;

    state_t      state_q;
    logic [1:0]  sclk_sync_q, csb_sync_q, sdi_sync_q;
    logic        sclk_prev_q, csb_prev_q;
    logic        armed_q;
    logic        cpol_q, cpha_q, lsb_q, large_q;
    logic [4:0]  bit_cnt_q;
    logic [23:0] tx_q, rx_q;

    logic        sclk_s, csb_s, sdi_s;
    logic        sclk_rise, sclk_fall, csb_rise, csb_fall;
    logic        lead_edge, trail_edge, sample_edge, shift_edge;
    logic [4:0]  frame_bits;
    logic        in_frame;
    logic [23:0] tx_load, tx_rest, tx_next, rx_next, word;
    logic        tx_first, tx_head;
    logic        dec_read;
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic [15:0] dec_wdata;

    always_comb begin
        sclk_s    = sclk_sync_q[1];
        csb_s     = csb_sync_q[1];
        sdi_s     = sdi_sync_q[1];
        sclk_rise = sclk_s & ~sclk_prev_q;
        sclk_fall = ~sclk_s & sclk_prev_q;
        csb_rise  = csb_s & ~csb_prev_q;
        csb_fall  = ~csb_s & csb_prev_q;

        lead_edge   = cpol_q ? sclk_fall : sclk_rise;
        trail_edge  = cpol_q ? sclk_rise : sclk_fall;
        sample_edge = cpha_q ? trail_edge : lead_edge;
        // With cpha=1 the first leading edge (no samples yet) keeps bit 0 on the wire.
        shift_edge  = cpha_q ? (lead_edge && (bit_cnt_q != 5'd0)) : trail_edge;

        frame_bits = large_q ? 5'd24 : 5'd16;
        in_frame   = bit_cnt_q < frame_bits;

        // TX shifter holds the bits still to be sent; its head moves toward the
        // wire end (bit 23 for MSB-first, bit 0 for LSB-first).
        tx_load  = (lsb_q || large_q) ? {8'h00, regRdData} : {regRdData, 8'h00};
        tx_first = lsb_q ? tx_load[0] : tx_load[23];
        tx_rest  = lsb_q ? (tx_load >> 1) : (tx_load << 1);
        tx_head  = lsb_q ? tx_q[0] : tx_q[23];
        tx_next  = lsb_q ? (tx_q >> 1) : (tx_q << 1);

        rx_next = lsb_q ? {sdi_s, rx_q[23:1]} : {rx_q[22:0], sdi_s};

        // LSB-first 16-bit frames end up in the upper part of the RX shifter.
        if (large_q) begin
            word = rx_q;
        end else if (lsb_q) begin
            word = {8'h00, rx_q[23:8]};
        end else begin
            word = {8'h00, rx_q[15:0]};
        end
        dec_read  = large_q ? word[23] : word[15];
        dec_addr  = large_q ? word[22:16] : word[14:8];
        dec_wdata = large_q ? word[15:0] : {8'h00, word[7:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sclk_sync_q <= '0;
            csb_sync_q  <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            large_q     <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            SPI_SDO     <= 1'b0;
            sdoEnable   <= 1'b0;
            regAddr     <= '0;
            regWrData   <= '0;
            regWrStrobe <= 1'b0;
            frameError  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SPI_CLK};
            csb_sync_q  <= {csb_sync_q[0], SPI_CSB};
            sdi_sync_q  <= {sdi_sync_q[0], SPI_SDI};
            sclk_prev_q <= sclk_s;
            csb_prev_q  <= csb_s;
            regWrStrobe <= 1'b0;
            frameError  <= 1'b0;
            // A reset taken while selected leaves armed low until CSB is seen high,
            // so the tail of the interrupted frame is ignored.
            if (csb_s) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    SPI_SDO <= 1'b0;
                    if (csb_fall && armed_q) begin
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        lsb_q   <= lsbFirst;
                        large_q <= largeTransfer;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    SPI_SDO   <= tx_first;
                    tx_q      <= tx_rest;
                    rx_q      <= '0;
                    bit_cnt_q <= '0;
                    sdoEnable <= 1'b1;
                    busy      <= 1'b1;
                    state_q   <= csb_rise ? StDone : StShift;
                end
                StShift: begin
                    // A CSB rise takes priority over any SPI clock edge in the same cycle.
                    if (csb_rise) begin
                        state_q <= StDone;
                    end else begin
                        if (sample_edge) begin
                            if (in_frame) begin
                                rx_q <= rx_next;
                            end
                            if (bit_cnt_q != 5'd31) begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                        if (shift_edge && in_frame) begin
                            SPI_SDO <= tx_head;
                            tx_q    <= tx_next;
                        end
                    end
                end
                StDone: begin
                    if (bit_cnt_q == frame_bits) begin
                        regAddr <= dec_addr;
                        if (!dec_read) begin
                            regWrData   <= dec_wdata;
                            regWrStrobe <= 1'b1;
                        end
                    end else begin
                        frameError <= 1'b1;
                    end
                    SPI_SDO   <= 1'b0;
                    sdoEnable <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/generic_spi_responder.md
Name: generic_spi_responder

Overview:
SPI peripheral (responder) end of the generic SPI link. It sits behind one SPI_CSB line, oversamples the SPI pins on the system clock, and decodes 16- or 24-bit frames into register write strobes. It returns read data with pipelined-read semantics: the word shifted out in a frame is the register addressed by the previous frame. Mode settings (CPOL, CPHA, bit order, frame length) match the initiator's CSR mode bits.

Parameters:
CLK_RATE, 100000000, system clock frequency in Hz.
BIT_RATE, 12500000, maximum SPI bit rate in Hz. Elaboration fails unless CLK_RATE >= 8*BIT_RATE.
ADDR_WIDTH, 7, register address width. Fixed at 7; the frame layout depends on it.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous assert, active-low.
cpol  in  1  SPI clock idle level.
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
lsbFirst  in  1  1: word bit 0 is on the wire first.
largeTransfer  in  1  1: 24-bit frame; 0: 16-bit frame.
SPI_CLK  in  1  SPI clock from the initiator (asynchronous).
SPI_CSB  in  1  chip select, active-low (asynchronous).
SPI_SDI  in  1  initiator-to-responder data.
SPI_SDO  out  1  responder-to-initiator data.
sdoEnable  out  1  1 while selected; drives the pad tristate.
regAddr  out  7  address of the last completed frame; this is also the readback address.
regWrData  out  16  write data of the last completed frame.
regWrStrobe  out  1  one-cycle write pulse.
regRdData  in  16  register contents at regAddr; sampled at frame start.
frameError  out  1  one-cycle pulse when a frame is aborted.
busy  out  1  1 while a frame is in progress.

Behaviour:
- Reset values: all outputs 0, except SPI_SDO=0 and sdoEnable=0. Internally: armed=0, bit counter=0, shifters=0.
- Synchronisation: SPI_CLK, SPI_CSB and SPI_SDI each pass through 2 flops. Edges are detected on the synchronised copies, giving 3 clk of latency from pin to action.
- cpol, cpha, lsbFirst and largeTransfer are latched at frame start and held for the whole frame.
- Bit counts: N = 16 (largeTransfer=0) or 24 (largeTransfer=1).
- Logical word W[N-1:0]:
  - W[N-1] = read flag; 1 suppresses the write.
  - W[N-2:N-8] = address.
  - Remaining low bits = data (8 bits in 16-bit mode, zero-extended into regWrData; 16 bits in 24-bit mode).
- Wire order: W[N-1] first when lsbFirst=0, W[0] first when lsbFirst=1.
- States:
  - IDLE: waits for a synchronised CSB falling edge. If armed=0 (reset occurred while CSB was low), no frame starts; armed sets on the first synchronised CSB high.
  - LOAD: one cycle. Loads the TX shifter with R = {8'h00, regRdData} truncated to N bits, placing R's first wire bit on SPI_SDO. Asserts sdoEnable and busy, clears the bit counter.
  - SHIFT:
    - Leading edge = rising edge if cpol=0, falling edge if cpol=1.
    - cpha=0: sample SPI_SDI on the leading edge; advance SPI_SDO on the trailing edge.
    - cpha=1: advance SPI_SDO on the leading edge, except the first leading edge, which leaves bit 0 in place; sample SPI_SDI on the trailing edge.
    - The bit counter counts samples and saturates at 31.
  - DONE (entered on synchronised CSB rising edge):
    - If count == N: update regAddr. If the read flag is 0, also update regWrData and pulse regWrStrobe.
    - Otherwise: pulse frameError; regAddr and regWrData stay unchanged.
    - Either way, deassert sdoEnable and busy and return to IDLE.
- Latency: regWrStrobe (or frameError) rises exactly 4 rising clk edges after the CSB pin rise.
- Extra SPI_CLK edges: edges after N samples or while CSB is high do not shift or sample (a frame with more than N samples is aborted).
- CSB rise and a clock edge detected in the same cycle: the CSB rise wins and the edge is discarded.
- SPI_SDO in IDLE is driven 0.
- Reset mid-frame: everything returns to reset values immediately, and the frame is discarded with no strobe and no error. The responder ignores the rest of that frame until CSB goes high.

Test Plan:
- 16-bit write, lsbFirst=1, cpol=0, cpha=0, word 0x07AA -> one regWrStrobe; regAddr=0x07, regWrData=0x00AA; frameError=0.
- Same as above with cpha=1 -> identical result; also check SDO timing against an initiator model sampling on trailing edges.
- Pipelined read, msbFirst, mode 0:
  - Frame 0x8700 -> no write strobe; regAddr=0x07.
  - Bench drives regRdData=0x55AA; next frame 0x0000 -> initiator receives 0x55AA and regWrStrobe writes 0x0000 to address 0x00.
- 24-bit write, lsbFirst=0, cpol=1, cpha=1, word 0x123456 -> regAddr=0x12, regWrData=0x3456, one strobe.
- Aborted frames:
  - 10-bit frame (CSB released early) -> frameError pulse; no regWrStrobe; regAddr unchanged.
  - 17-bit frame in 16-bit mode -> also aborted.
- Reset mid-frame:
  - rst_n low after 5 bits -> all outputs 0 immediately; remaining SCLKs ignored; no strobe.
  - Next full frame after CSB goes high decodes correctly.
